// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the LCD pixel streamer.
package lcd_pkg;

    localparam int LCD_HACTIVE   = 480;
    localparam int LCD_VACTIVE   = 272;
    localparam int LCD_FRAME_PIX = LCD_HACTIVE * LCD_VACTIVE;
    localparam int CNT_W         = 17;

    // RGB565 field offsets within a 16-bit pixel
    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_STREAM   = 2'd2;

    typedef struct packed {
        logic        sof;
        logic [15:0] data;
    } pix_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; extra pointer MSB tells full from empty.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lcd_pixel_stream.sv
// Buffers upstream RGB565 pixels and emits one per DE cycle, aligned with the
// one-cycle-delayed panel syncs; resynchronises on underflow or misframing.
module lcd_pixel_stream
    import lcd_pkg::*;
#(
    parameter int HACTIVE = LCD_HACTIVE,
    parameter int VACTIVE = LCD_VACTIVE,
    parameter int DEPTH   = 16
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    output logic        s_ready,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        underflow,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(HACTIVE * VACTIVE - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [15:0]      rgb_q, rgb_d;
    logic             uf_q, uf_d, fe_q, fe_d;
    logic             de_q, hs_q, vs_q, rdy_q;
    logic             pop, full, empty, vs_fall;
    logic [16:0]      head_raw;
    pix_entry_t       head;

    sync_fifo #(.WIDTH($bits(pix_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (PixelClk),
        .rst_n_i (nRST),
        .push_i  (s_valid && s_ready),
        .wdata_i ({s_sof, s_data}),
        .pop_i   (pop),
        .head_o  (head_raw),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head    = pix_entry_t'(head_raw);
    // rdy_q keeps s_ready low while in reset even though the FIFO reads empty
    assign s_ready = rdy_q && !full;
    assign vs_fall = !vsync_in && vs_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        rgb_d   = '0;
        uf_d    = 1'b0;
        fe_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_WAIT_SOF: begin
                if (!empty) begin
                    if (head.sof)  state_d = ST_ARMED;
                    else if (de_in) pop = 1'b1;
                end
            end
            ST_ARMED: begin
                if (vs_fall) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                end
            end
            ST_STREAM: begin
                if (vs_fall) begin
                    fe_d    = 1'b1;
                    state_d = ST_WAIT_SOF;
                end else if (de_in) begin
                    if (empty) begin
                        uf_d    = 1'b1;
                        state_d = ST_WAIT_SOF;
                    end else if (head.sof && cnt_q != '0) begin
                        // leave the early SOF at the head so WAIT_SOF re-arms on it
                        fe_d    = 1'b1;
                        state_d = ST_WAIT_SOF;
                    end else begin
                        pop   = 1'b1;
                        rgb_d = head.data;
                        if (cnt_q == LAST_PIX) begin
                            cnt_d   = '0;
                            fcnt_d  = fcnt_q + 16'd1;
                            state_d = ST_ARMED;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_WAIT_SOF;
        endcase
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_WAIT_SOF;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            rgb_q   <= '0;
            uf_q    <= 1'b0;
            fe_q    <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            rgb_q   <= rgb_d;
            uf_q    <= uf_d;
            fe_q    <= fe_d;
            de_q    <= de_in;
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
            rdy_q   <= 1'b1;
        end
    end

    assign LCD_DE    = de_q;
    assign LCD_HSYNC = hs_q;
    assign LCD_VSYNC = vs_q;
    assign LCD_R     = rgb_q[R_LSB +: R_W];
    assign LCD_G     = rgb_q[G_LSB +: G_W];
    assign LCD_B     = rgb_q[B_LSB +: B_W];
    assign underflow = uf_q;
    assign frame_err = fe_q;
    assign frame_cnt = fcnt_q;

endmodule
